// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI device endpoint:
//   - spi_state_e       : device frame state machine encoding
//   - CPOL/CPHA/MSB_FIRST: fixed bus mode (mode 0, MSB first)
//   - DEFAULT_SYNC_STAGES: default depth of the input synchronizers
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
//   STAGES-deep synchronizer for one asynchronous input, followed by a
//   registered copy used to detect rising and falling edges.
//   Ports:
//     clk   in   device clock
//     rst   in   asynchronous active-high reset (flops load RST_VAL)
//     din   in   raw asynchronous input
//     dout  out  synchronized level
//     rise  out  one-cycle pulse on a synchronized 0->1 transition
//     fall  out  one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = spi_pkg::DEFAULT_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: non-blocking assignments in clocked blocks, so every flop samples
  // the pre-edge value of its neighbour and the chain really shifts by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_device.sv
// ---------------------------------------------------------------------------
// spi_device
//   SPI mode-0 device endpoint. Shifts in a DW-bit command word on MOSI
//   (MSB first) and returns an RX-bit response on MISO during the last RX
//   bit times of the same frame. SCK/CSN/MOSI are oversampled on clk.
//   Ports:
//     clk        in   device clock (>=4 clk per SCK phase)
//     rst        in   asynchronous active-high reset
//     spi_sck    in   serial clock, idle low
//     spi_csn    in   chip select, active low
//     spi_mosi   in   host-to-device data
//     spi_miso   out  device-to-host data
//     resp_data  in   response word, captured at frame start
//     rx_data    out  last complete command word
//     rx_valid   out  one-cycle pulse when rx_data updates
//     frame_err  out  one-cycle pulse when a frame ends with a bad bit count
//     busy       out  synchronized CSN is low
// ---------------------------------------------------------------------------
module spi_device
  import spi_pkg::*;
#(
  parameter int DW          = 16,
  parameter int RX          = 8,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_sck,
  input  logic          spi_csn,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic [RX-1:0] resp_data,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          busy
);

  localparam int             CW      = $clog2(DW + 1);
  localparam int             PAD     = DW - RX;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DW);

  logic sck_s, sck_rise, sck_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk (clk), .rst (rst), .din (spi_sck),
    .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk (clk), .rst (rst), .din (spi_csn),
    .dout(csn_s), .rise(csn_rise), .fall(csn_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk (clk), .rst (rst), .din (spi_mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the level of MOSI and the edges of SCK are needed.
  logic unused_sync;
  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

  spi_state_e     state;
  logic [CW-1:0]  cnt;
  logic [RX-1:0]  tx_reg;
  logic [DW-1:0]  rx_sh;
  logic           pending;   // CSN fell while in DONE; start on return to IDLE
  logic           fall_bit;

  // MISO value for frame bit k: zeros while k < DW-RX, then response MSB
  // first. Loop-compare keeps the index select width-clean.
  function automatic logic bit_for(input logic [CW-1:0] k,
                                   input logic [RX-1:0] tx);
    logic b;
    int   idx;
    b   = 1'b0;
    idx = RX - 1 - (int'(k) - PAD);
    for (int i = 0; i < RX; i++) begin
      if (i == idx) b = tx[i];
    end
    return b;
  endfunction

  // NOTE: the default assignment first means every path writes fall_bit, so
  // no latch is inferred.
  always_comb begin
    fall_bit = 1'b0;
    if (cnt < CNT_MAX) fall_bit = bit_for(cnt, tx_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_reg    <= '0;
      rx_sh     <= '0;
      pending   <= 1'b0;
      spi_miso  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (csn_fall || pending) begin
            tx_reg   <= resp_data;
            rx_sh    <= '0;
            cnt      <= '0;
            spi_miso <= bit_for('0, resp_data);
            pending  <= 1'b0;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          // CSN rising takes priority over any coincident SCK edge.
          if (csn_rise) begin
            state <= DONE;
          end else if (sck_rise) begin
            if (cnt < CNT_MAX) begin
              rx_sh <= {rx_sh[DW-2:0], mosi_s};
              cnt   <= cnt + CW'(1);
            end
          end else if (sck_fall) begin
            spi_miso <= fall_bit;
          end
        end
        DONE: begin
          if (cnt == CNT_MAX) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          spi_miso <= 1'b0;
          cnt      <= '0;
          pending  <= csn_fall;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = ~csn_s;

endmodule

// File: tb/tb_spi_device.sv
// ---------------------------------------------------------------------------
// tb_spi_device
//   Directed bench for spi_device: a DW=16/RX=8 instance and a DW=8/RX=8
//   instance share SCK and MOSI but have separate chip selects. A host task
//   drives mode-0 frames (6 clk per SCK phase) and collects MISO.
// ---------------------------------------------------------------------------
module tb_spi_device;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        csn16 = 1'b1;
  logic        csn8 = 1'b1;
  logic [7:0]  resp16 = 8'h00;
  logic [7:0]  resp8 = 8'h00;

  logic        miso16, miso8;
  logic [15:0] rx_data16;
  logic [7:0]  rx_data8;
  logic        rx_valid16, rx_valid8;
  logic        frame_err16, frame_err8;
  logic        busy16, busy8;

  int checks = 0;
  int errors = 0;
  int v16 = 0, e16 = 0, v8 = 0, e8 = 0;
  logic [7:0] q8[$];

  always #5 clk = ~clk;

  spi_device #(.DW(16), .RX(8), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_csn(csn16), .spi_mosi(mosi),
    .spi_miso(miso16), .resp_data(resp16), .rx_data(rx_data16),
    .rx_valid(rx_valid16), .frame_err(frame_err16), .busy(busy16)
  );

  spi_device #(.DW(8), .RX(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_csn(csn8), .spi_mosi(mosi),
    .spi_miso(miso8), .resp_data(resp8), .rx_data(rx_data8),
    .rx_valid(rx_valid8), .frame_err(frame_err8), .busy(busy8)
  );

  // Pulse monitors (sampled away from the active edge).
  always @(negedge clk) begin
    if (rx_valid16 === 1'b1) v16++;
    if (frame_err16 === 1'b1) e16++;
    if (rx_valid8 === 1'b1) begin
      v8++;
      q8.push_back(rx_data8);
    end
    if (frame_err8 === 1'b1) e8++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 frame. Bit k of the frame is bits[nbits-1-k]. The host samples
  // MISO just before each SCK rise. resp16 changes to chg_val after bit chg_at.
  task automatic do_frame(input bit use8, input int nbits,
                          input logic [31:0] bits, input bit end_csn,
                          input int chg_at, input logic [7:0] chg_val,
                          output logic [31:0] got);
    @(negedge clk);
    if (use8) csn8 = 1'b0; else csn16 = 1'b0;
    mosi = bits[nbits-1];
    wait_clk(HALF);
    got = '0;
    for (int k = 0; k < nbits; k++) begin
      got = {got[30:0], (use8 ? miso8 : miso16)};
      sck = 1'b1;
      wait_clk(HALF);
      if (k == chg_at) resp16 = chg_val;
      sck = 1'b0;
      if (k + 1 < nbits) mosi = bits[nbits-2-k];
      wait_clk(HALF);
    end
    if (end_csn) begin
      if (use8) csn8 = 1'b1; else csn16 = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] got, got2;
    int v_snap, e_snap;
    logic [15:0] d_snap;

    // Reset state
    wait_clk(4);
    check("reset_miso", miso16, 1'b0);
    check("reset_rx_data", rx_data16, 16'h0000);
    check("reset_rx_valid", rx_valid16, 1'b0);
    check("reset_frame_err", frame_err16, 1'b0);
    check("reset_busy", busy16, 1'b0);
    rst = 1'b0;
    wait_clk(4);

    // Full 16-bit frame: response in the last 8 bits, zeros before.
    resp16 = 8'h5A;
    do_frame(1'b0, 16, 32'h0000A5C3, 1'b1, -1, 8'h00, got);
    wait_clk(10);
    check("f16_host_rx", got, 32'h0000005A);
    check("f16_rx_data", rx_data16, 16'hA5C3);
    check("f16_valid_cnt", v16, 1);
    check("f16_err_cnt", e16, 0);
    check("f16_miso_idle", miso16, 1'b0);

    // Back-to-back 8-bit frames with a single-clk CSN gap.
    resp8 = 8'hFF;
    do_frame(1'b1, 8, 32'h00000081, 1'b1, -1, 8'h00, got);
    resp8 = 8'h00;
    do_frame(1'b1, 8, 32'h0000007E, 1'b1, -1, 8'h00, got2);
    wait_clk(10);
    check("f8a_host_rx", got, 32'h000000FF);
    check("f8b_host_rx", got2, 32'h00000000);
    check("f8_valid_cnt", v8, 2);
    check("f8_first_word", (q8.size() > 0) ? q8[0] : 8'hxx, 8'h81);
    check("f8_second_word", (q8.size() > 1) ? q8[1] : 8'hxx, 8'h7E);
    check("f8_final_rx_data", rx_data8, 8'h7E);
    check("f8_err_cnt", e8, 0);
    check("f16_untouched_by_f8", v16, 1);

    // Short frame: 5 SCK cycles.
    do_frame(1'b0, 5, 32'h00000016, 1'b1, -1, 8'h00, got);
    wait_clk(10);
    check("short_err_cnt", e16, 1);
    check("short_valid_cnt", v16, 1);
    check("short_rx_data_kept", rx_data16, 16'hA5C3);
    check("short_miso_zero", miso16, 1'b0);

    // resp_data change mid-frame has no effect until the next frame.
    resp16 = 8'h5A;
    do_frame(1'b0, 16, 32'h00001111, 1'b1, 3, 8'hC3, got);
    wait_clk(10);
    check("chg_host_rx_old", got, 32'h0000005A);
    check("chg_rx_data", rx_data16, 16'h1111);
    do_frame(1'b0, 16, 32'h00002222, 1'b1, -1, 8'h00, got);
    wait_clk(10);
    check("chg_host_rx_new", got, 32'h000000C3);
    check("chg_rx_data2", rx_data16, 16'h2222);
    check("chg_valid_cnt", v16, 3);

    // Reset after 9 bits, CSN raised while in reset.
    v_snap = v16;
    e_snap = e16;
    do_frame(1'b0, 9, 32'h000001FF, 1'b0, -1, 8'h00, got);
    rst = 1'b1;
    csn16 = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    check("rst_mid_rx_data", rx_data16, 16'h0000);
    check("rst_mid_miso", miso16, 1'b0);
    check("rst_mid_busy", busy16, 1'b0);
    rst = 1'b0;
    wait_clk(10);
    check("rst_mid_no_valid", v16 - v_snap, 0);
    check("rst_mid_no_err", e16 - e_snap, 0);
    check("rst_mid_rx_valid", rx_valid16, 1'b0);
    resp16 = 8'h96;
    do_frame(1'b0, 16, 32'h00001234, 1'b1, -1, 8'h00, got);
    wait_clk(10);
    check("post_rst_rx_data", rx_data16, 16'h1234);
    check("post_rst_valid", v16 - v_snap, 1);
    check("post_rst_host_rx", got, 32'h00000096);

    // 18 SCK cycles: the two extra bits are ignored, MISO 0 for them.
    v_snap = v16;
    e_snap = e16;
    resp16 = 8'h3C;
    do_frame(1'b0, 18, 32'h0002FBBF, 1'b1, -1, 8'h00, got);
    wait_clk(10);
    check("long_rx_data", rx_data16, 16'hBEEF);
    check("long_valid", v16 - v_snap, 1);
    check("long_err", e16 - e_snap, 0);
    check("long_host_rx", got, 32'h000000F0);

    // SCK toggling with CSN high changes nothing.
    v_snap = v16;
    e_snap = e16;
    d_snap = rx_data16;
    for (int i = 0; i < 4; i++) begin
      mosi = ~mosi;
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
      wait_clk(HALF);
    end
    wait_clk(6);
    check("idle_sck_rx_data", rx_data16, d_snap);
    check("idle_sck_valid", v16 - v_snap, 0);
    check("idle_sck_err", e16 - e_snap, 0);
    check("idle_sck_miso", miso16, 1'b0);
    check("idle_sck_busy", busy16, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
